taylor_series_driver: RTL and testbench

//  Initiator side of the cosine-core start/ready_out handshake. Queues angle requests

---
 rtl/taylor_series_driver.sv | 129 ++++++++++++
 tb/tb_taylor_series_driver.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/taylor_series_driver.sv
// Request FIFO plus two-state launcher for the cosine core, with result capture
// onto a valid/ready output stream and a watchdog for a core that never answers.
module taylor_series_driver #(
  parameter int W          = 24,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_angle,
  output logic         core_start,
  output logic [W-1:0] core_angle,
  input  logic         core_ready,
  input  logic [W-1:0] core_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic         out_timeout,
  output logic         busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state_q, state_d;

  logic [W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop;

  logic          rdy_q, res_edge;
  logic [TW-1:0] wd;
  logic          cap_ok, cap_to, out_free;

  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign in_ready = ~full;
  assign push     = in_valid & in_ready;
  assign res_edge = core_ready & ~rdy_q;
  assign out_free = ~out_valid | out_ready;
  assign busy     = (state_q != IDLE) | ~empty;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_angle;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    cap_ok  = 1'b0;
    cap_to  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && out_free) begin
          pop     = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // Only a rising edge of ready counts, so a level left high by the last job is ignored.
        if (res_edge) begin
          cap_ok  = 1'b1;
          state_d = IDLE;
        end else if (wd == TW'(TIMEOUT - 1)) begin
          cap_to  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdy_q       <= 1'b0;
      wd          <= '0;
      core_start  <= 1'b0;
      core_angle  <= '0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_timeout <= 1'b0;
    end else begin
      rdy_q <= core_ready;
      if (pop) begin
        core_angle <= mem[rd_ptr];
        core_start <= 1'b1;
        wd         <= '0;
      end else if (state_q == RUN) begin
        wd <= wd + 1'b1;
      end
      if (cap_ok || cap_to) begin
        core_start  <= 1'b0;
        out_valid   <= 1'b1;
        out_result  <= cap_ok ? core_result : '0;
        out_timeout <= cap_to;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_taylor_series_driver.sv
// Randomized scoreboard bench for taylor_series_driver with a behavioural cosine core.
module tb_taylor_series_driver;

  localparam int W       = 24;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_angle = '0;
  logic         core_start;
  logic [W-1:0] core_angle;
  logic         core_ready;
  logic [W-1:0] core_result;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_result;
  logic         out_timeout;
  logic         busy;

  taylor_series_driver #(.W(W), .FIFO_DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_angle(in_angle),
    .core_start(core_start), .core_angle(core_angle),
    .core_ready(core_ready), .core_result(core_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_timeout(out_timeout), .busy(busy)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [W-1:0] cosq(input logic [W-1:0] a);
    real x;
    x = $itor($signed(a)) / 8388608.0;
    return W'($rtoi($cos(x) * 8388608.0 + 0.5));
  endfunction

  typedef struct packed {
    logic         to;
    logic [W-1:0] r;
  } exp_t;
  exp_t exp_q[$];

  bit dead   = 1'b0;
  bit lag_en = 1'b0;

  // Cosine core model: samples the angle on start, computes, raises ready with cos(angle).
  int           cst, ccnt, clag;
  logic [W-1:0] cang;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      cst <= 0; ccnt <= 0; clag <= 0; cang <= '0;
      core_ready <= 1'b0; core_result <= '0;
    end else begin
      case (cst)
        0: if (core_start) begin
          cang <= core_angle;
          ccnt <= 5;
          clag <= lag_en ? int'($urandom_range(4, 1)) : 0;
          if (!lag_en) core_ready <= 1'b0;
          cst <= 1;
        end
        1: if (!core_start) begin
          core_ready <= 1'b0;
          cst <= 0;
        end else if (clag != 0) begin
          clag <= clag - 1;
          if (clag == 1) core_ready <= 1'b0;
        end else if (!dead) begin
          if (ccnt == 1) begin
            core_ready  <= 1'b1;
            core_result <= cosq(cang);
            cst <= 2;
          end else begin
            ccnt <= ccnt - 1;
            core_result <= W'($urandom);
          end
        end
        default: cst <= 0;
      endcase
    end
  end

  // Output monitor: pops the scoreboard on each transfer, checks stability while stalled.
  bit           hold_prev = 1'b0;
  logic [W-1:0] prev_r;
  logic         prev_to;
  always @(negedge clock) begin
    if (reset) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_result", {8'd0, out_result}, {8'd0, prev_r});
        check("hold_timeout", {31'd0, out_timeout}, {31'd0, prev_to});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result", {8'd0, out_result}, {8'd0, e.r});
          check("timeout_flag", {31'd0, out_timeout}, {31'd0, e.to});
        end
      end
      hold_prev = out_valid && !out_ready;
      prev_r    = out_result;
      prev_to   = out_timeout;
    end
  end

  function automatic exp_t expect_for(input logic [W-1:0] a);
    exp_t e;
    e.to = dead;
    e.r  = dead ? '0 : cosq(a);
    return e;
  endfunction

  // Called just after a rising edge; returns after the transfer edge.
  task automatic push_one(input logic [W-1:0] a, output int stalls);
    in_valid = 1'b1;
    in_angle = a;
    stalls   = 0;
    @(negedge clock);
    while (!in_ready && stalls < 300) begin
      stalls++;
      @(negedge clock);
    end
    if (!in_ready) check("push_wait", 32'd1, 32'd0);
    else exp_q.push_back(expect_for(a));
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || out_valid || exp_q.size() != 0) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check("drain_bound", {31'd0, n >= 2000}, 32'd0);
    @(posedge clock); #1;
  endtask

  initial begin
    int st;
    int exp_st[6] = '{0, 0, 0, 0, 0, 5};

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_core_start", {31'd0, core_start}, 32'd0);
    check("rst_core_angle", {8'd0, core_angle}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_result", {8'd0, out_result}, 32'd0);
    check("rst_out_timeout", {31'd0, out_timeout}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // 1: single zero angle, latency
    @(posedge clock); #1;
    in_valid = 1'b1; in_angle = '0;
    exp_q.push_back(expect_for('0));
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(negedge clock);
    check("t1_start_early", {31'd0, core_start}, 32'd0);
    @(negedge clock);
    check("t1_start", {31'd0, core_start}, 32'd1);
    repeat (6) @(negedge clock);
    check("t1_valid_early", {31'd0, out_valid}, 32'd0);
    @(negedge clock);
    check("t1_valid", {31'd0, out_valid}, 32'd1);
    check("t1_cos0", {8'd0, out_result}, 32'h0080_0000);
    wait_idle();

    // 2: back-to-back stream fills the FIFO
    for (int k = 0; k < 6; k++) begin
      push_one(W'($urandom), st);
      check($sformatf("t2_stalls%0d", k), st, exp_st[k]);
    end
    wait_idle();

    // 3: consumer stalls, second launch waits for the output slot
    out_ready = 1'b0;
    push_one(W'($urandom), st);
    push_one(W'($urandom), st);
    begin
      int n = 0;
      while (!out_valid && n < 200) begin @(negedge clock); n++; end
      check("t3_first_bound", {31'd0, out_valid}, 32'd1);
    end
    repeat (12) @(negedge clock);
    check("t3_no_launch", {31'd0, core_start}, 32'd0);
    check("t3_busy", {31'd0, busy}, 32'd1);
    @(posedge clock); #1 out_ready = 1'b1;
    @(posedge clock); #1 out_ready = 1'b0;
    begin
      int n = 0;
      @(negedge clock);
      while (!out_valid && n < 200) begin @(negedge clock); n++; end
      check("t3_second_bound", {31'd0, out_valid}, 32'd1);
    end
    repeat (4) @(negedge clock);
    @(posedge clock); #1 out_ready = 1'b1;
    wait_idle();

    // 4: dead core, watchdog
    dead = 1'b1;
    in_valid = 1'b1; in_angle = W'($urandom);
    exp_q.push_back(expect_for(in_angle));
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (TIMEOUT + 1) @(negedge clock);
    check("t4_valid_early", {31'd0, out_valid}, 32'd0);
    check("t4_start_held", {31'd0, core_start}, 32'd1);
    @(negedge clock);
    check("t4_valid", {31'd0, out_valid}, 32'd1);
    check("t4_timeout", {31'd0, out_timeout}, 32'd1);
    check("t4_result", {8'd0, out_result}, 32'd0);
    check("t4_start_drop", {31'd0, core_start}, 32'd0);
    wait_idle();
    dead = 1'b0;

    // 5: stale-high ready lingers after launch
    lag_en = 1'b1;
    for (int k = 0; k < 3; k++) push_one(W'($urandom), st);
    wait_idle();

    // random traffic with random consumer back-pressure
    fork
      begin
        for (int k = 0; k < 20; k++) begin
          repeat ($urandom_range(3, 0)) @(posedge clock);
          #1 push_one(W'($urandom), st);
        end
      end
      begin
        repeat (400) begin
          @(posedge clock); #1;
          out_ready = 1'($urandom_range(1, 0));
        end
      end
    join
    out_ready = 1'b1;
    wait_idle();
    lag_en = 1'b0;

    // 6: reset during RUN
    for (int k = 0; k < 3; k++) push_one(W'($urandom), st);
    begin
      int n = 0;
      while (!core_start && n < 100) begin @(negedge clock); n++; end
      check("t6_start_bound", {31'd0, core_start}, 32'd1);
    end
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_start", {31'd0, core_start}, 32'd0);
    check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("t6_post_busy", {31'd0, busy}, 32'd0);
    check("t6_post_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clock); #1;
    push_one(W'($urandom), st);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
